jc_cycle_controller: RTL
========================

Name: jc_cycle_controller

Overview:
Sequencing controller for the team's Johnson-counter phase generator. It accepts a command "run N full Johnson cycles" over a valid/ready handshake, then steps an internal 2*WIDTH-state Johnson register through exactly N cycles. It publishes the raw count and a one-hot phase decode, and signals completion. It also supports abort and recovers from illegal counter codes.

Parameters:
WIDTH, 4, Johnson register width; the sequence length is 2*WIDTH states.
CNT_W, 8, width of the cycle-count command and of cycles_left.

Ports:
clk  in  1  clock; all state updates on the rising edge.
clear  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command (high only in IDLE).
cmd_cycles  in  CNT_W  number of full Johnson cycles to run.
abort  in  1  terminate the current run (honoured in RUN only).
count  out  WIDTH  Johnson register value.
phase  out  2*WIDTH  one-hot phase index of count; all zeros if count is illegal.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse on normal completion.
cycles_left  out  CNT_W  full cycles still to run.
err_illegal  out  1  one-cycle pulse when an illegal count is repaired.

Behaviour:
- Reset (clear=1, async): state=IDLE, count=0, cycles_left=0, busy=0, done=0, err_illegal=0; cmd_ready=1 once clear is released. Reset mid-run discards the run immediately.
- States: IDLE, RUN.
- IDLE:
  - count is held at 0.
  - Accept on cmd_valid&cmd_ready at edge k.
  - If cmd_cycles==0: done=1 for the cycle after edge k, remain in IDLE, count unchanged.
  - Otherwise: cycles_left<=cmd_cycles, go to RUN; busy=1 from edge k.
  - abort is ignored in IDLE; cmd_valid+abort in the same cycle still accepts the command.
- RUN:
  - Each edge steps count forward: shift right, MSB<=~LSB (0000,1000,1100,1110,1111,0111,0011,0001,0000 for WIDTH=4).
  - Wrap = step from the last state to 0; on wrap cycles_left decrements.
  - Wrap with cycles_left==1: go to IDLE, busy<=0, done<=1 for one cycle, cycles_left<=0.
  - Latency: command accepted at edge k -> done high after edge k+2*WIDTH*N. Total busy time is 2*WIDTH*N cycles.
  - cmd_ready=1 in the done cycle, so a back-to-back command is accepted on that edge.
- abort in RUN: at the next edge go to IDLE, count=0, cycles_left=0, busy=0, no done pulse.
- Illegal count in RUN (not one of the 2*WIDTH Johnson codes):
  - Next edge forces count=0 and pulses err_illegal; cycles_left is unchanged and no wrap is counted.
  - The run continues.
  - phase=0 while count is illegal.
- abort and illegal count in the same cycle: abort wins; err_illegal is still pulsed.
- phase is combinational from count; done and err_illegal are registered.
- cycles_left never underflows.

Optional Feature:
JC_REVERSE_EN:
- Defined: adds input port dir (1 bit) after cmd_cycles. dir is latched at command acceptance and held for the whole run. dir=1 steps backward (0000,0001,0011,0111,1111,1110,1100,1000,0000); the wrap is the step 1000->0000. The phase index counts along the forward sequence regardless of direction.
- Undefined: no dir port; forward stepping only.

Decomposition:
- Package jc_ctrl_pkg: state encoding (IDLE, RUN); localparam for sequence length; functions jc_is_legal(count) and jc_phase(count) returning the one-hot decode.
- Sub-module jc_core:
  - Inputs: clk, clear, step, zero, dir.
  - Outputs: count, wrap, illegal.
  - Owns the Johnson register and its repair logic; jc_cycle_controller holds the FSM, the handshake and cycles_left.

Test Plan:
1. Normal run (WIDTH=4): cmd_cycles=2 accepted at edge 0 -> count follows 0000,1000,...,0001,0000 twice; cycles_left 2->1 at edge 8 and 1->0 at edge 16; busy high for 16 cycles; done single pulse after edge 16.
2. Zero count: cmd_cycles=0 -> done pulse on the next cycle; busy never high; count stays 0000.
3. Abort: cmd_cycles=3, abort high on the 5th RUN cycle -> next edge count=0000, busy=0, cycles_left=0, no done pulse.
4. Illegal repair: deposit count=1010 mid-run -> phase=0 in that cycle; next edge count=0000 and err_illegal pulses once; cycles_left unchanged; the run completes with extra cycles.
5. Async reset: assert clear between edges during RUN -> all outputs return to reset values immediately, without waiting for a clock edge.
6. Back-to-back: hold cmd_valid with cmd_cycles=1 -> second command accepted on the done edge; busy low for exactly one cycle between runs. With JC_REVERSE_EN and dir=1, count follows 0000,0001,0011,... and wraps via 1000->0000.

Source files
------------

// File: rtl/jc_ctrl_pkg.sv
// Shared types and Johnson-code helpers for the cycle controller and its counter core.
// Codes up to JC_MAX_W bits wide are handled; callers pass the live width.
package jc_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } jc_state_e;

  localparam int JC_MAX_W   = 16;
  localparam int JC_MAX_SEQ = 2 * JC_MAX_W;

  // A Johnson code has at most one 0/1 boundary between adjacent bits.
  function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] c, input int w);
    int edges;
    edges = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i < w - 1) && (c[i] != c[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

  // Forward-sequence index: MSB set means the ones are still filling (index = ones),
  // MSB clear means they are draining from the top (index = 2w - ones).
  function automatic logic [JC_MAX_SEQ-1:0] jc_phase(input logic [JC_MAX_W-1:0] c, input int w);
    logic [JC_MAX_SEQ-1:0] oh;
    int ones;
    int idx;
    oh   = '0;
    ones = 0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if ((i < w) && c[i]) ones++;
    end
    if (c[w-1])        idx = ones;
    else if (ones == 0) idx = 0;
    else               idx = 2 * w - ones;
    if (jc_is_legal(c, w)) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/jc_core.sv
// Johnson register with forward/backward stepping, wrap detection and illegal-code repair.
module jc_core
  import jc_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             step,
  input  logic             zero,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] fwd_nxt;
  logic [WIDTH-1:0] rev_nxt;
  logic [WIDTH-1:0] nxt;

  assign fwd_nxt = {~cnt_q[0], cnt_q[WIDTH-1:1]};
  assign rev_nxt = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
  assign nxt     = dir ? rev_nxt : fwd_nxt;

  assign illegal = ~jc_is_legal(JC_MAX_W'(cnt_q), WIDTH);

  // Only a legal last-state code steps to all zeros, so this is a true cycle boundary.
  assign wrap  = step & ~zero & ~illegal & (nxt == '0);
  assign count = cnt_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (zero) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= illegal ? '0 : nxt;
    end
  end

endmodule

// File: rtl/jc_cycle_controller.sv
// Command-driven sequencer running N full Johnson cycles, with abort and code repair.
// Optional JC_REVERSE_EN adds a dir input latched per command for backward stepping.
module jc_cycle_controller
  import jc_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   cmd_cycles,
`ifdef JC_REVERSE_EN
  input  logic               dir,
`endif
  input  logic               abort,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycles_left,
  output logic               err_illegal
);

  jc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic             core_step;
  logic             core_zero;
  logic             core_wrap;
  logic             core_illegal;
  logic             cmd_dir;
  logic [JC_MAX_SEQ-1:0] phase_full;

`ifdef JC_REVERSE_EN
  assign cmd_dir = dir;
`else
  assign cmd_dir = 1'b0;
`endif

  jc_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .clear   (clear),
    .step    (core_step),
    .zero    (core_zero),
    .dir     (dir_q),
    .count   (count),
    .wrap    (core_wrap),
    .illegal (core_illegal)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    core_step = 1'b0;
    core_zero = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort has no meaning here; a coincident command is still taken.
        core_zero = 1'b1;
        if (cmd_valid) begin
          if (cmd_cycles == '0) begin
            done_d = 1'b1;
          end else begin
            cyc_d   = cmd_cycles;
            dir_d   = cmd_dir;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        err_d = core_illegal;
        if (abort) begin
          core_zero = 1'b1;
          cyc_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_wrap && (cyc_q != '0)) begin
            cyc_d = cyc_q - CNT_W'(1);
            if (cyc_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign done        = done_q;
  assign err_illegal = err_q;
  assign cycles_left = cyc_q;

  assign phase_full = jc_phase(JC_MAX_W'(count), WIDTH);
  assign phase      = phase_full[2*WIDTH-1:0];

  generate
    if (WIDTH < JC_MAX_W) begin : g_phase_hi
      logic unused_phase_hi;
      assign unused_phase_hi = ^phase_full[JC_MAX_SEQ-1:2*WIDTH];
    end
  endgenerate

endmodule
